// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out transmitter. It accepts a word over a valid/ready handshake
// and shifts it out MSB- or LSB-first, one bit per enabled clock.
module piso_serial_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             dir,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             dir_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
    end
  end

  // Next-state and handshake/serial outputs
  always_comb begin
    state_nxt  = state;
    sreg_nxt   = sreg;
    cnt_nxt    = cnt;
    dir_nxt    = dir;
    in_ready   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sreg_nxt  = in_data;
          dir_nxt   = in_dir;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        sout       = dir ? sreg[0] : sreg[WIDTH-1];
        sout_valid = en;
        last       = en && (cnt == '0);
        if (en) begin
          if (cnt != '0) begin
            sreg_nxt = dir ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
            cnt_nxt  = cnt - CW'(1);
          end else begin
            // Final bit: accept the next word in the same cycle for zero-gap frames
            in_ready = 1'b1;
            if (in_valid) begin
              sreg_nxt = in_data;
              dir_nxt  = in_dir;
              cnt_nxt  = CW'(WIDTH - 1);
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are quiet during the reset cycle even though state is not yet cleared
    if (!rstn) begin
      in_ready   = 1'b0;
      sout       = 1'b0;
      sout_valid = 1'b0;
      last       = 1'b0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed and loopback bench for piso_serial_tx, with a behavioural model of the
// bidirectional serial-in receiver.
module tb_piso_serial_tx;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rstn;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_dir;
  logic         en;
  logic         sout;
  logic         sout_valid;
  logic         dir;
  logic         last;
  logic         busy;

  int checks;
  int errors;

  logic [W-1:0] rx;

  piso_serial_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dir     (in_dir),
    .en         (en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .dir        (dir),
    .last       (last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Receiver: d=sout, en=sout_valid, dir=dir; dir=0 shifts left, dir=1 shifts right
  always @(posedge clk) begin
    if (sout_valid) rx <= dir ? {sout, rx[W-1:1]} : {rx[W-2:0], sout};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one word while idle, then stream it with en=1 and compare against seq
  task automatic send_full(input logic [W-1:0] word, input logic d, input logic [W-1:0] seq,
                           input string tag);
    in_valid = 1'b1; in_data = word; in_dir = d; en = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_data = '0; in_dir = ~d;
    #1;
    for (int i = 0; i < int'(W); i++) begin
      check({tag, "_sout"}, 32'(sout), 32'(seq[W-1-i]));
      check({tag, "_valid"}, 32'(sout_valid), 32'd1);
      check({tag, "_last"}, 32'(last), 32'(i == int'(W) - 1));
      check({tag, "_dir"}, 32'(dir), 32'(d));
      tick();
    end
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W-1:0] seq_b4_msb;
    logic [W-1:0] seq_b4_lsb;
    logic [W-1:0] seq_3c_lsb;
    logic [W-1:0] seq_81_msb;
    logic [15:0]  en_pat;
    logic [15:0]  seq_b2b;
    logic [W-1:0] word;
    int           idx;
    int           c;
    bit           done;

    seq_b4_msb = 8'b1011_0100;
    seq_b4_lsb = 8'b0010_1101;
    seq_3c_lsb = 8'b0011_1100;
    seq_81_msb = 8'b1000_0001;
    en_pat     = 16'b1001_1010_1101_0011;
    checks = 0; errors = 0;
    clk = 1'b0; rx = '0;
    rstn = 1'b0; in_valid = 1'b1; in_data = 8'hB4; in_dir = 1'b0; en = 1'b1;

    // 1. reset with in_valid high
    #1;
    for (int i = 0; i < 3; i++) begin
      check("t1_ready", 32'(in_ready), 32'd0);
      check("t1_svalid", 32'(sout_valid), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);
      tick();
    end
    check("t1_sout", 32'(sout), 32'd0);
    check("t1_dir", 32'(dir), 32'd0);
    in_valid = 1'b0; rstn = 1'b1;
    tick();
    check("t1_no_accept", 32'(busy), 32'd0);
    check("t1_ready_idle", 32'(in_ready), 32'd1);

    // 2/3. single frames in each order
    send_full(8'hB4, 1'b0, seq_b4_msb, "t2");
    send_full(8'hB4, 1'b1, seq_b4_lsb, "t3");

    // 4. en stalls mid-word
    in_valid = 1'b1; in_data = 8'hB4; in_dir = 1'b0; en = 1'b1;
    tick();
    in_valid = 1'b0;
    idx = 0; c = 0;
    while (idx < int'(W) && c < 40) begin
      en = en_pat[15 - (c % 16)];
      #1;
      check("t4_sout", 32'(sout), 32'(seq_b4_msb[W-1-idx]));
      check("t4_svalid", 32'(sout_valid), 32'(en));
      check("t4_busy", 32'(busy), 32'd1);
      if (en) idx++;
      c++;
      tick();
    end
    check("t4_strobes", 32'(idx), 32'(W));
    check("t4_idle", 32'(busy), 32'd0);

    // 5. back-to-back frames, second accepted on the last bit of the first
    en = 1'b1; in_valid = 1'b1; in_data = 8'hB4; in_dir = 1'b0;
    tick();
    in_data = 8'h3C; in_dir = 1'b1;
    seq_b2b = {seq_b4_msb, seq_3c_lsb};
    for (int i = 0; i < 16; i++) begin
      if (i == 15) in_valid = 1'b0;
      #1;
      check("t5_sout", 32'(sout), 32'(seq_b2b[15-i]));
      check("t5_svalid", 32'(sout_valid), 32'd1);
      check("t5_dir", 32'(dir), 32'(i >= 8));
      check("t5_last", 32'(last), 32'(i == 7 || i == 15));
      check("t5_ready", 32'(in_ready), 32'(i == 7 || i == 15));
      tick();
    end
    check("t5_idle", 32'(busy), 32'd0);

    // 6. reset mid-frame, then a clean frame
    in_valid = 1'b1; in_data = 8'hB4; in_dir = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rstn = 1'b0;
    #1;
    check("t6_rst_svalid", 32'(sout_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    tick();
    rstn = 1'b1;
    #1;
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_sout", 32'(sout), 32'd0);
    check("t6_idle_dir", 32'(dir), 32'd0);
    check("t6_idle_ready", 32'(in_ready), 32'd1);
    send_full(8'h81, 1'b0, seq_81_msb, "t6");

    // 7. random loopback into the receiver model
    for (int w = 0; w < 20; w++) begin
      word = W'($urandom);
      in_valid = 1'b1; in_data = word; in_dir = 1'($urandom_range(0, 1)); en = 1'b1;
      #1;
      check("t7_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0; in_data = ~word;
      done = 1'b0; c = 0;
      while (!done && c < 200) begin
        en = ($urandom_range(0, 3) != 0);
        #1;
        if (last) begin
          tick();
          check("t7_rx", 32'(rx), 32'(word));
          done = 1'b1;
        end else begin
          tick();
        end
        c++;
      end
      check("t7_done", 32'(done), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
